// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared constants, state type and sizing helper for the config loader
//
// Contents:
//   SYNC_DEFAULT  default frame start marker
//   cfg_state_t   loader FSM states
//   nw()          number of bitstream words needed to cover a configuration word
package cfg_pkg;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_t;

    function automatic int nw(input int cfg_w, input int dw);
        return (cfg_w + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/cfg_shadow_reg.sv
// rtl/cfg_shadow_reg.sv - word-indexed shadow register with top-word truncation
//
// Ports:
//   clk      clock
//   rst      synchronous active-high reset, clears the shadow
//   wr_en    write word wr_idx this cycle
//   wr_idx   word index (0..NW-1)
//   wr_data  word written into shadow[wr_idx*DW +: DW]; bits at or above CFG_W are dropped
//   shadow   current shadow contents
module cfg_shadow_reg #(
    parameter int CFG_W = 44,
    parameter int DW    = 8,
    parameter int NW    = (CFG_W + DW - 1) / DW,
    parameter int IW    = $clog2(NW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [DW-1:0]    wr_data,
    output logic [CFG_W-1:0] shadow
);

    logic [CFG_W-1:0] shadow_q;
    logic [CFG_W-1:0] shadow_d;

    // Each shadow bit knows statically which word and which bit of that word
    // feeds it, so the truncated top word simply has fewer bits wired.
    for (genvar b = 0; b < CFG_W; b++) begin : g_bit
        localparam int K = b / DW;
        localparam int J = b % DW;
        assign shadow_d[b] = (wr_en && (wr_idx == IW'(K))) ? wr_data[J] : shadow_q[b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow = shadow_q;

endmodule

// File: rtl/config_loader.sv
// rtl/config_loader.sv - framed bitstream loader with XOR checksum and atomic commit
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset; aborts any frame and clears c
//   din        bitstream word
//   din_valid  din holds a valid word
//   din_ready  loader accepts din this cycle (low only in COMMIT)
//   c          committed configuration word
//   cset       one-cycle pulse in the first cycle c shows a new value
//   busy       a frame is in progress
//   done       one-cycle pulse, frame committed (coincides with cset)
//   err        one-cycle pulse, checksum mismatch and frame dropped
//
// Frame: SYNC, NW data words (word 0 is least significant), XOR checksum of the
// full data words.
module config_loader
    import cfg_pkg::*;
#(
    parameter int            CFG_W = 44,
    parameter int            DW    = 8,
    parameter logic [DW-1:0] SYNC  = SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [CFG_W-1:0] c,
    output logic             cset,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int NW = nw(CFG_W, DW);
    localparam int CW = $clog2(NW + 1);

    cfg_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [CFG_W-1:0] c_q, c_d;
    logic             cset_q, cset_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             wr_en;
    logic [CFG_W-1:0] shadow;

    assign din_ready = (state_q != COMMIT);
    assign xfer      = din_valid && din_ready;

    cfg_shadow_reg #(
        .CFG_W (CFG_W),
        .DW    (DW),
        .NW    (NW),
        .IW    (CW)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (cnt_q),
        .wr_data (din),
        .shadow  (shadow)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        c_d     = c_q;
        cset_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Non-SYNC words are swallowed so the loader resynchronises
                // on the next marker.
                if (xfer && (din == SYNC)) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            LOAD: begin
                // SYNC values here are ordinary data.
                if (xfer) begin
                    wr_en = 1'b1;
                    acc_d = acc_q ^ din;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(NW - 1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (din == acc_q) begin
                        state_d = COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            COMMIT: begin
                // c and the pulses update on the same edge so consumers see
                // cset together with the new word.
                c_d     = shadow;
                cset_d  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            cset_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            cset_q  <= cset_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign c    = c_q;
    assign cset = cset_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != IDLE);

endmodule
